// File: rtl/vga_tile_pixel_gen.sv
// Tile-RAM pixel generator sitting after the VGA sync generator: three p_tick stages
// turning (pixel_x, pixel_y) into registered RGB with matched sync. Define VGA_TILE_CURSOR_EN for the blinking cursor.
module vga_tile_pixel_gen #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 60,
    parameter logic [2:0] BG_COLOR     = 3'b000,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        wr_strobe,
    input  logic [12:0] wr_addr,
    input  logic [3:0]  wr_data,
    input  logic        cur_wr,
    input  logic [6:0]  cur_col,
    input  logic [5:0]  cur_row,
    output logic [2:0]  rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam int DEPTH = COLS * ROWS;

    logic [3:0] tile_mem [0:DEPTH-1];

    // Stage 1 registers
    logic [6:0] col1_q, col1_d;
    logic [5:0] row1_q, row1_d;
    logic [2:0] sx1_q, sx1_d, sy1_q, sy1_d;
    logic       von1_q, von1_d, grid1_q, grid1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    // Stage 2 registers
    logic [2:0] sx2_q, sx2_d, sy2_q, sy2_d;
    logic       von2_q, von2_d, grid2_q, grid2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic [3:0] data2_q, data2_d;
    // Stage 3 (output) registers
    logic [2:0] rgb_q, rgb_d;
    logic       hs3_q, hs3_d, vs3_q, vs3_d;

    logic [12:0] rd_addr_s;
    logic [2:0]  color_s;
    logic        in_grid_s;

`ifdef VGA_TILE_CURSOR_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [6:0]    col2_q, col2_d, cur_col_q, cur_col_d;
    logic [5:0]    row2_q, row2_d, cur_row_q, cur_row_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic          vs_rise_s;
`else
    logic unused_cursor_s;
    assign unused_cursor_s = ^{cur_wr, cur_col, cur_row};
`endif

    logic unused_py_s;
    assign unused_py_s = pixel_y[9];

    // Tile RAM write port; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (wr_strobe && (wr_addr < 13'(DEPTH))) begin
            tile_mem[wr_addr] <= wr_data;
        end
    end

    // Read address, grid test and stage-3 colour selection
    always_comb begin
        in_grid_s = (32'(pixel_x[9:3]) < COLS) && (32'(pixel_y[8:3]) < ROWS);
        rd_addr_s = 13'(row1_q) * 13'(COLS) + 13'(col1_q);
        if (!von2_q) begin
            color_s = 3'b000;
        end else if (!grid2_q) begin
            color_s = BG_COLOR;
        end else if (data2_q[3] && ((sx2_q == 3'd0) || (sy2_q == 3'd0))) begin
            color_s = BG_COLOR;
        end else begin
            color_s = data2_q[2:0];
        end
    end

    // Next-state logic: every stage holds unless p_tick
    always_comb begin
        col1_d = col1_q;  row1_d = row1_q;  sx1_d = sx1_q;  sy1_d = sy1_q;
        von1_d = von1_q;  grid1_d = grid1_q; hs1_d = hs1_q; vs1_d = vs1_q;
        sx2_d = sx2_q;    sy2_d = sy2_q;    von2_d = von2_q; grid2_d = grid2_q;
        hs2_d = hs2_q;    vs2_d = vs2_q;    data2_d = data2_q;
        rgb_d = rgb_q;    hs3_d = hs3_q;    vs3_d = vs3_q;
        if (p_tick) begin
            col1_d  = pixel_x[9:3];
            row1_d  = pixel_y[8:3];
            sx1_d   = pixel_x[2:0];
            sy1_d   = pixel_y[2:0];
            von1_d  = video_on;
            grid1_d = in_grid_s;
            hs1_d   = hsync_in;
            vs1_d   = vsync_in;
            sx2_d   = sx1_q;
            sy2_d   = sy1_q;
            von2_d  = von1_q;
            grid2_d = grid1_q;
            hs2_d   = hs1_q;
            vs2_d   = vs1_q;
            // Read-first: a same-clock write lands after this read
            data2_d = grid1_q ? tile_mem[rd_addr_s] : 4'b0000;
            rgb_d   = color_s;
            hs3_d   = hs2_q;
            vs3_d   = vs2_q;
        end else begin
            rgb_d = rgb_q;
        end
`ifdef VGA_TILE_CURSOR_EN
        if (p_tick && von2_q && grid2_q && blink_phase_q &&
            (col2_q == cur_col_q) && (row2_q == cur_row_q)) begin
            rgb_d = ~color_s;
        end else begin
            rgb_d = rgb_d;
        end
`endif
    end

    // Pipeline registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col1_q <= 7'd0;   row1_q <= 6'd0;   sx1_q <= 3'd0;   sy1_q <= 3'd0;
            von1_q <= 1'b0;   grid1_q <= 1'b0;  hs1_q <= 1'b0;   vs1_q <= 1'b0;
            sx2_q <= 3'd0;    sy2_q <= 3'd0;    von2_q <= 1'b0;  grid2_q <= 1'b0;
            hs2_q <= 1'b0;    vs2_q <= 1'b0;    data2_q <= 4'd0;
            rgb_q <= 3'd0;    hs3_q <= 1'b0;    vs3_q <= 1'b0;
        end else begin
            col1_q <= col1_d; row1_q <= row1_d; sx1_q <= sx1_d; sy1_q <= sy1_d;
            von1_q <= von1_d; grid1_q <= grid1_d; hs1_q <= hs1_d; vs1_q <= vs1_d;
            sx2_q <= sx2_d;   sy2_q <= sy2_d;   von2_q <= von2_d; grid2_q <= grid2_d;
            hs2_q <= hs2_d;   vs2_q <= vs2_d;   data2_q <= data2_d;
            rgb_q <= rgb_d;   hs3_q <= hs3_d;   vs3_q <= vs3_d;
        end
    end

`ifdef VGA_TILE_CURSOR_EN
    // Cursor position load and blink timing; vs1_q is the previous sampled vsync
    always_comb begin
        col2_d        = p_tick ? col1_q : col2_q;
        row2_d        = p_tick ? row1_q : row2_q;
        cur_col_d     = cur_wr ? cur_col : cur_col_q;
        cur_row_d     = cur_wr ? cur_row : cur_row_q;
        vs_rise_s     = p_tick && vsync_in && !vs1_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (vs_rise_s) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = {BW{1'b0}};
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
    end

    // Cursor and blink registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col2_q        <= 7'd0;
            row2_q        <= 6'd0;
            cur_col_q     <= 7'd0;
            cur_row_q     <= 6'd0;
            blink_cnt_q   <= {BW{1'b0}};
            blink_phase_q <= 1'b0;
        end else begin
            col2_q        <= col2_d;
            row2_q        <= row2_d;
            cur_col_q     <= cur_col_d;
            cur_row_q     <= cur_row_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`endif

    assign rgb       = rgb_q;
    assign hsync_out = hs3_q;
    assign vsync_out = vs3_q;

endmodule

// File: tb/tb_vga_tile_pixel_gen.sv
// Directed table-driven bench for vga_tile_pixel_gen; cursor checks need VGA_TILE_CURSOR_EN.
module tb_vga_tile_pixel_gen;

    logic        clk = 1'b0;
    logic        reset, p_tick, video_on, hsync_in, vsync_in;
    logic [9:0]  pixel_x, pixel_y;
    logic        wr_strobe, cur_wr;
    logic [12:0] wr_addr;
    logic [3:0]  wr_data;
    logic [6:0]  cur_col;
    logic [5:0]  cur_row;
    logic [2:0]  rgb;
    logic        hsync_out, vsync_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic [2:0] exp_rgb;
    } vec_t;

    vec_t vecs [11];

    vga_tile_pixel_gen dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_wr(cur_wr), .cur_col(cur_col), .cur_row(cur_row),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic tick(input logic [9:0] x, input logic [9:0] y,
                        input logic von, input logic hs, input logic vs);
        pixel_x = x; pixel_y = y; video_on = von; hsync_in = hs; vsync_in = vs;
        p_tick = 1'b1;
        @(posedge clk);
        #1;
        p_tick = 1'b0;
    endtask

    task automatic idle();
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [12:0] a, input logic [3:0] d);
        wr_strobe = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1;
        wr_strobe = 1'b0;
    endtask

    task automatic show(input string nm, input logic [9:0] x, input logic [9:0] y,
                        input logic [2:0] exp);
        tick(x, y, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        chk(nm, rgb, exp);
    endtask

    initial begin
        reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        pixel_x = 10'd0; pixel_y = 10'd0; wr_strobe = 1'b0; wr_addr = 13'd0;
        wr_data = 4'd0; cur_wr = 1'b0; cur_col = 7'd0; cur_row = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", rgb, 3'b000);
        chk("reset_hs", {2'b00, hsync_out}, 3'b000);
        chk("reset_vs", {2'b00, vsync_out}, 3'b000);
        reset = 1'b0;

        wr(13'd0, 4'b0100);
        wr(13'd1, 4'b1000);
        wr(13'd2, 4'b0110);
        wr(13'd79, 4'b0101);
        wr(13'd81, 4'b1010);
        wr(13'd82, 4'b0001);
        wr(13'd4799, 4'b0011);
        wr(13'd4800, 4'b0111);
        wr(13'd8191, 4'b0111);

        // Exact latency of a single pixel
        tick(10'd3, 10'd3, 1'b1, 1'b0, 1'b0);
        tick(10'd650, 10'd0, 1'b1, 1'b0, 1'b0);
        chk("lat_t2", rgb, 3'b000);
        tick(10'd650, 10'd0, 1'b1, 1'b0, 1'b0);
        chk("lat_t3", rgb, 3'b100);
        idle();
        chk("lat_t4", rgb, 3'b000);

        vecs[0]  = '{10'd3,   10'd3,   1'b1, 1'b1, 1'b0, 3'b100};
        vecs[1]  = '{10'd8,   10'd8,   1'b1, 1'b0, 1'b1, 3'b000};
        vecs[2]  = '{10'd12,  10'd8,   1'b1, 1'b1, 1'b1, 3'b000};
        vecs[3]  = '{10'd9,   10'd9,   1'b1, 1'b0, 1'b0, 3'b010};
        vecs[4]  = '{10'd16,  10'd0,   1'b1, 1'b1, 1'b0, 3'b110};
        vecs[5]  = '{10'd639, 10'd0,   1'b1, 1'b0, 1'b1, 3'b101};
        vecs[6]  = '{10'd632, 10'd472, 1'b1, 1'b0, 1'b0, 3'b011};
        vecs[7]  = '{10'd650, 10'd0,   1'b1, 1'b1, 1'b0, 3'b000};
        vecs[8]  = '{10'd3,   10'd3,   1'b0, 1'b0, 1'b0, 3'b000};
        vecs[9]  = '{10'd0,   10'd480, 1'b1, 1'b0, 1'b1, 3'b000};
        vecs[10] = '{10'd17,  10'd9,   1'b1, 1'b1, 1'b1, 3'b001};

        for (int i = 0; i < 11; i++) begin
            tick(vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].hs, vecs[i].vs);
            idle();
            idle();
            chk($sformatf("vec%0d_rgb", i), rgb, vecs[i].exp_rgb);
            chk($sformatf("vec%0d_hs", i), {2'b00, hsync_out}, {2'b00, vecs[i].hs});
            chk($sformatf("vec%0d_vs", i), {2'b00, vsync_out}, {2'b00, vecs[i].vs});
        end

        // p_tick low: every stage must hold
        tick(10'd3, 10'd3, 1'b1, 1'b1, 1'b0);
        tick(10'd9, 10'd9, 1'b1, 1'b0, 1'b1);
        tick(10'd16, 10'd0, 1'b1, 1'b1, 1'b0);
        chk("pre_freeze_rgb", rgb, 3'b100);
        pixel_x = 10'd650; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("freeze_rgb", rgb, 3'b100);
        chk("freeze_hs", {2'b00, hsync_out}, 3'b001);
        chk("freeze_vs", {2'b00, vsync_out}, 3'b000);
        idle();
        chk("unfreeze_rgb", rgb, 3'b010);
        chk("unfreeze_hs", {2'b00, hsync_out}, 3'b000);
        chk("unfreeze_vs", {2'b00, vsync_out}, 3'b001);
        idle();
        chk("unfreeze2_rgb", rgb, 3'b110);

        // Write to the tile being read in the same clk returns old data
        wr(13'd3, 4'b0001);
        tick(10'd24, 10'd0, 1'b1, 1'b0, 1'b0);
        wr_strobe = 1'b1; wr_addr = 13'd3; wr_data = 4'b0010;
        idle();
        wr_strobe = 1'b0;
        idle();
        chk("rdfirst_old", rgb, 3'b001);
        show("rdfirst_new", 10'd24, 10'd0, 3'b010);

        // Asynchronous reset mid-line, then 3-tick recovery
        tick(10'd3, 10'd3, 1'b1, 1'b1, 1'b1);
        tick(10'd3, 10'd3, 1'b1, 1'b1, 1'b1);
        tick(10'd3, 10'd3, 1'b1, 1'b1, 1'b1);
        chk("pre_rst_rgb", rgb, 3'b100);
        chk("pre_rst_hs", {2'b00, hsync_out}, 3'b001);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_rgb", rgb, 3'b000);
        chk("midrst_hs", {2'b00, hsync_out}, 3'b000);
        chk("midrst_vs", {2'b00, vsync_out}, 3'b000);
        @(posedge clk);
        #2;
        reset = 1'b0;
        tick(10'd3, 10'd3, 1'b1, 1'b1, 1'b1);
        tick(10'd3, 10'd3, 1'b1, 1'b1, 1'b1);
        chk("rec_t2_hs", {2'b00, hsync_out}, 3'b000);
        chk("rec_t2_rgb", rgb, 3'b000);
        tick(10'd3, 10'd3, 1'b1, 1'b1, 1'b1);
        chk("rec_t3_hs", {2'b00, hsync_out}, 3'b001);
        chk("rec_t3_vs", {2'b00, vsync_out}, 3'b001);
        chk("rec_t3_rgb", rgb, 3'b100);

`ifdef VGA_TILE_CURSOR_EN
        // Blink cursor at tile (col 2, row 1)
        pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        cur_wr = 1'b1; cur_col = 7'd2; cur_row = 6'd1;
        @(posedge clk);
        #1;
        cur_wr = 1'b0;
        show("cur_phase0", 10'd17, 10'd9, 3'b001);
        for (int f = 0; f < 29; f++) begin
            tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
            idle();
        end
        show("cur_29frames", 10'd17, 10'd9, 3'b001);
        tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        idle();
        show("cur_30frames", 10'd17, 10'd9, 3'b110);
        show("cur_other_tile", 10'd9, 10'd9, 3'b010);
        for (int f = 0; f < 30; f++) begin
            tick(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
            idle();
        end
        show("cur_60frames", 10'd17, 10'd9, 3'b001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
